// File: rtl/vga_pkg.sv
// Shared framebuffer geometry and the scan capture pipe-tag encoding.
package vga_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 12;
  localparam int FB_W      = 320;
  localparam int FB_H      = 240;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_RD    = 2'd1,
    TAG_BLANK = 2'd2
  } pipe_tag_e;

endpackage

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads take absolute priority,
// pixel writes fill the remaining RAM cycles under a req/ack handshake.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       wr_stall_cnt
);

  logic              w_scan_rd;
  logic              w_wr_grant;
  logic              w_stall;
  pipe_tag_e         w_tag_in;

  pipe_tag_e         r_tag0;
  pipe_tag_e         r_tag1;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_wr_ack;
  logic [DATA_W-1:0] r_scan_data;
  logic              r_scan_valid;
  logic [15:0]       r_stall_cnt;

  // A blanked pixel slot leaves the port free, so a write may share that edge.
  always_comb begin
    w_scan_rd  = pix_en & scan_req;
    w_wr_grant = wr_req & ~r_wr_ack & ~w_scan_rd;
    w_stall    = wr_req & ~r_wr_ack & ~w_wr_grant;
    w_tag_in   = TAG_NONE;
    if (pix_en) begin
      w_tag_in = scan_req ? TAG_RD : TAG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_wr_ack    <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_grant;
      if (w_scan_rd) begin
        r_ram_en   <= 1'b1;
        r_ram_we   <= 1'b0;
        r_ram_addr <= scan_addr;
      end else if (w_wr_grant) begin
        r_ram_en    <= 1'b1;
        r_ram_we    <= 1'b1;
        r_ram_addr  <= wr_addr;
        r_ram_wdata <= wr_data;
      end else begin
        r_ram_en <= 1'b0;
        r_ram_we <= 1'b0;
      end
    end
  end

  // Tag reaches stage 1 on the edge the RAM samples; rdata is captured one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag0       <= TAG_NONE;
      r_tag1       <= TAG_NONE;
      r_scan_data  <= '0;
      r_scan_valid <= 1'b0;
    end else begin
      r_tag0       <= w_tag_in;
      r_tag1       <= r_tag0;
      r_scan_valid <= (r_tag1 != TAG_NONE);
      if (r_tag1 == TAG_RD) begin
        r_scan_data <= ram_rdata;
      end else if (r_tag1 == TAG_BLANK) begin
        r_scan_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign ram_en       = r_ram_en;
  assign ram_we       = r_ram_we;
  assign ram_addr     = r_ram_addr;
  assign ram_wdata    = r_ram_wdata;
  assign wr_ack       = r_wr_ack;
  assign scan_data    = r_scan_data;
  assign scan_valid   = r_scan_valid;
  assign wr_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural synchronous-read RAM.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        scan_req;
  logic [16:0] scan_addr;
  logic [11:0] scan_data;
  logic        scan_valid;
  logic        wr_req;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        ram_en;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic [15:0] wr_stall_cnt;

  logic [11:0] mem [0:(1<<17)-1];
  int          ram_wr_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_wr_cnt    <= ram_wr_cnt + 1;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  vga_fb_arbiter #(.ADDR_W(17), .DATA_W(12)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .pix_en       (pix_en),
    .scan_req     (scan_req),
    .scan_addr    (scan_addr),
    .scan_data    (scan_data),
    .scan_valid   (scan_valid),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ack       (wr_ack),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .wr_stall_cnt (wr_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [16:0] a, input logic [11:0] d);
    bit seen = 1'b0;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (wr_ack) seen = 1'b1;
    end
    check("wr_ack_seen", 32'(seen), 32'd1);
    check("wr_grant_we", 32'(ram_we), 32'd1);
    wr_req = 1'b0;
    tick();
  endtask

  task automatic do_scan(input logic [16:0] a, input logic [11:0] exp);
    pix_en    = 1'b1;
    scan_req  = 1'b1;
    scan_addr = a;
    tick();
    pix_en   = 1'b0;
    scan_req = 1'b0;
    check("scan_ram_en", 32'(ram_en), 32'd1);
    check("scan_ram_we", 32'(ram_we), 32'd0);
    check("scan_ram_addr", 32'(ram_addr), 32'(a));
    tick();
    check("scan_valid_early", 32'(scan_valid), 32'd0);
    tick();
    check("scan_valid", 32'(scan_valid), 32'd1);
    check("scan_data", 32'(scan_data), 32'(exp));
    tick();
    check("scan_valid_pulse", 32'(scan_valid), 32'd0);
    check("scan_data_hold", 32'(scan_data), 32'(exp));
  endtask

  initial begin
    int wcnt0;
    int ack_cnt;
    int last_ack;
    int idx;
    bit gap_ok;
    bit any_ack;
    logic [16:0] b2b_addr [4];
    logic [11:0] b2b_data [4];

    b2b_addr[0] = 17'h00100; b2b_data[0] = 12'h111;
    b2b_addr[1] = 17'h00101; b2b_data[1] = 12'h2A2;
    b2b_addr[2] = 17'h00102; b2b_data[2] = 12'h3C3;
    b2b_addr[3] = 17'h00103; b2b_data[3] = 12'hFE4;

    reset = 1'b1; pix_en = 1'b0; scan_req = 1'b0; scan_addr = '0;
    wr_req = 1'b1; wr_addr = 17'h00055; wr_data = 12'h777;

    // Reset held two clocks with a pending write.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_wr_ack", 32'(wr_ack), 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      check("rst_stall", 32'(wr_stall_cnt), 32'd0);
    end
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    check("rst_scan_data", 32'(scan_data), 32'd0);
    check("rst_scan_valid", 32'(scan_valid), 32'd0);
    check("rst_no_ram_write", 32'(ram_wr_cnt), 32'd0);
    reset = 1'b0; wr_req = 1'b0;
    tick();

    // Preload and scan read.
    do_write(17'h00010, 12'hABC);
    check("preload_stall", 32'(wr_stall_cnt), 32'd0);
    do_scan(17'h00010, 12'hABC);

    // Blanking slot.
    pix_en = 1'b1; scan_req = 1'b0;
    tick();
    pix_en = 1'b0;
    check("blank_ram_en", 32'(ram_en), 32'd0);
    tick();
    tick();
    check("blank_valid", 32'(scan_valid), 32'd1);
    check("blank_data", 32'(scan_data), 32'h000);
    tick();
    check("blank_valid_pulse", 32'(scan_valid), 32'd0);

    // Collision: scan wins, write granted on the following edge.
    pix_en = 1'b1; scan_req = 1'b1; scan_addr = 17'h00010;
    wr_req = 1'b1; wr_addr = 17'h00020; wr_data = 12'h123;
    tick();
    pix_en = 1'b0; scan_req = 1'b0;
    check("col_scan_en", 32'(ram_en), 32'd1);
    check("col_scan_we", 32'(ram_we), 32'd0);
    check("col_ack_n", 32'(wr_ack), 32'd0);
    check("col_stall_n", 32'(wr_stall_cnt), 32'd1);
    tick();
    wr_req = 1'b0;
    check("col_ack", 32'(wr_ack), 32'd1);
    check("col_wr_we", 32'(ram_we), 32'd1);
    check("col_wr_addr", 32'(ram_addr), 32'h00020);
    check("col_wr_data", 32'(ram_wdata), 32'h123);
    tick();
    check("col_ack_pulse", 32'(wr_ack), 32'd0);
    check("col_scan_valid", 32'(scan_valid), 32'd1);
    check("col_scan_data", 32'(scan_data), 32'hABC);
    check("col_stall_final", 32'(wr_stall_cnt), 32'd1);
    tick();
    do_scan(17'h00020, 12'h123);

    // Back-to-back writes with blanked pixel slots every 4 clocks.
    wcnt0 = ram_wr_cnt; ack_cnt = 0; last_ack = -2; gap_ok = 1'b1; idx = 0;
    wr_req = 1'b1; wr_addr = b2b_addr[0]; wr_data = b2b_data[0];
    for (int c = 0; c < 30 && idx < 4; c++) begin
      pix_en = ((c % 4) == 0); scan_req = 1'b0;
      tick();
      if (wr_ack) begin
        if (c - last_ack != 2 && ack_cnt != 0) gap_ok = 1'b0;
        last_ack = c; ack_cnt++; idx++;
        if (idx < 4) begin
          wr_addr = b2b_addr[idx]; wr_data = b2b_data[idx];
        end else begin
          wr_req = 1'b0;
        end
      end
    end
    pix_en = 1'b0;
    tick(); tick(); tick();
    check("b2b_ack_cnt", 32'(ack_cnt), 32'd4);
    check("b2b_ack_gap", 32'(gap_ok), 32'd1);
    check("b2b_ram_writes", 32'(ram_wr_cnt - wcnt0), 32'd4);
    check("b2b_stall", 32'(wr_stall_cnt), 32'd1);
    for (int k = 0; k < 4; k++) do_scan(b2b_addr[k], b2b_data[k]);

    // Saturation, then reset on what would be a grant edge.
    wcnt0 = ram_wr_cnt; any_ack = 1'b0;
    pix_en = 1'b1; scan_req = 1'b1; scan_addr = 17'h00010;
    wr_req = 1'b1; wr_addr = 17'h00030; wr_data = 12'h555;
    for (int c = 0; c < 70000; c++) begin
      tick();
      if (wr_ack) any_ack = 1'b1;
    end
    check("sat_stall", 32'(wr_stall_cnt), 32'hFFFF);
    check("sat_no_ack", 32'(any_ack), 32'd0);
    check("sat_no_write", 32'(ram_wr_cnt - wcnt0), 32'd0);
    pix_en = 1'b0; scan_req = 1'b0; reset = 1'b1;
    tick();
    check("rmid_ack", 32'(wr_ack), 32'd0);
    check("rmid_ram_en", 32'(ram_en), 32'd0);
    check("rmid_stall", 32'(wr_stall_cnt), 32'd0);
    check("rmid_valid", 32'(scan_valid), 32'd0);
    reset = 1'b0; wr_req = 1'b0;
    tick(); tick();
    check("rmid_flushed", 32'(scan_valid), 32'd0);
    check("rmid_no_write", 32'(ram_wr_cnt - wcnt0), 32'd0);
    check("rmid_ack_after", 32'(wr_ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Single-port framebuffer arbiter that shares one synchronous-read block RAM between the VGA scan-out path and a pixel writer (game/draw logic). Scan-out reads have absolute priority and complete inside one pixel period. Writes use the remaining RAM cycles under a req/ack handshake. Sits between the pixel-timing controller (sync/active generation) and the RGB output register stage of the display top.

## Interface
Parameters:
- ADDR_W, 17, framebuffer word address width (320x240 = 76800 words)
- DATA_W, 12, pixel width (4-bit R, G, B packed {r,g,b})

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- pix_en  in  1  one-cycle pixel strobe from the clock divider; period ≥ 4 clk
- scan_req  in  1  video-active flag for the pixel being fetched
- scan_addr  in  ADDR_W  framebuffer address of that pixel
- scan_data  out  DATA_W  fetched pixel, or 0 when blanked
- scan_valid  out  1  one-cycle pulse: scan_data updated
- wr_req  in  1  writer requests a write
- wr_addr  in  ADDR_W  write address, held until ack
- wr_data  in  DATA_W  write data, held until ack
- wr_ack  out  1  one-cycle pulse: write committed to RAM port
- ram_en  out  1  RAM enable (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data, valid 1 clk after the access edge
- wr_stall_cnt  out  16  saturating count of cycles a write waited

## Operation
- Per-edge decision (priority order): reset; scan slot; write slot; idle.
- Scan slot: edge with pix_en=1. If scan_req=1: register ram_en=1, ram_we=0, ram_addr=scan_addr; set pipe tag RD. If scan_req=0: no RAM access, set pipe tag BLANK; port is free for a write at that edge.
- Capture stage: 2-stage tag pipeline. Tag RD → scan_data<=ram_rdata. Tag BLANK → scan_data<=0. Either way scan_valid pulses for one cycle.
- Write slot: edge where no scan read is issued, wr_req=1, and wr_ack is currently 0. Register ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, wr_ack=1.
- wr_req is ignored while wr_ack=1, so no double commit. Maximum write rate is one per 2 clk.
- Writer must hold wr_addr/wr_data stable from req until the ack cycle. It may drop or change them after the ack edge.
- Idle: ram_en=0, ram_we=0. ram_addr/ram_wdata hold their last value.
- wr_stall_cnt increments on every edge where wr_req=1, wr_ack=0, and the write was not granted (scan took the port). Saturates at 0xFFFF. Cleared only by reset.
- scan_data holds its value between scan_valid pulses.

## Timing
- Reset (synchronous, at the edge): all outputs 0 and tag pipeline flushed. Any access decided at that edge is dropped, and no wr_ack is issued for it.
- Scan latency: pix_en sampled at edge N → ram_en valid after N → RAM samples at N+1 → scan_data/scan_valid update at N+2. scan_valid is high during cycle N+2..N+3, before the next pix_en (edge N+4 at minimum).
- Write latency: wr_req sampled at grant edge G → wr_ack and ram_* valid during cycle G..G+1. RAM commits at G+1.
- Simultaneous pix_en & scan_req & wr_req: scan wins; write deferred ≥1 clk; stall counted.
- Simultaneous pix_en & !scan_req & wr_req: write granted at the same edge.
- Write followed by a read of the same address: the read returns new data if the write grant edge precedes the scan-slot edge. No bypass path.
- pix_en period < 4 clk: unsupported. The capture pipeline may overlap.

## Structure
- Shared package vga_pkg holds FB_ADDR_W, FB_DATA_W, FB_W=320, FB_H=240, and the pipe-tag encoding (NONE, RD, BLANK).
- Single module, no sub-modules. The RAM itself is instantiated by the display top, not inside this block.

## Test plan
- Reset: assert reset 2 clk with wr_req=1 → all outputs 0, no wr_ack, wr_stall_cnt=0.
- Scan read: preload addr 0x00010=0xABC; pix_en at edge N, scan_req=1, scan_addr=0x00010 → ram_en=1/ram_we=0 at N..N+1, scan_data=0xABC and scan_valid=1 at N+2.
- Blanking: pix_en with scan_req=0 → no ram_en; scan_data=0x000 with scan_valid pulse at N+2.
- Collision: wr_req (addr 0x00020, data 0x123) raised on the same edge as pix_en&scan_req → scan read first; write granted next edge; wr_ack one cycle; wr_stall_cnt=1; readback of 0x00020 = 0x123.
- Back-to-back writes: wr_req held high with new addr/data after each ack, pix_en every 4 clk, scan_req=0 → one ack per 2 clk; every write lands exactly once.
- Saturation/reset mid-op: hold wr_req with pix_en&scan_req forced every cycle for 70000 clk → wr_stall_cnt=0xFFFF. Then reset at a grant edge → counter 0, no ack, no RAM write.
